// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and types for the register-file write
//               arbiter: data/index widths, register count, B lock limit
//               and the arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  // Width of one architectural register value.
  localparam int DATA_W   = 32;
  // Register index width; NUM_REGS must equal 2**ADDR_W.
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;
  // Maximum number of back-to-back beats requester B may hold the port.
  localparam int LOCK_MAX = 8;

  // Arbiter state.
  //   RR     : round-robin between A (ALU) and B (load unit)
  //   LOCK_B : B owns the write port until it releases or hits LOCK_MAX
  typedef enum logic [0:0] {
    RR     = 1'b0,
    LOCK_B = 1'b1
  } arb_state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rf_wr_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_wr_scoreboard
// Description : Pending-write scoreboard. One bit per register; a bit is set
//               when a producer is allocated for that register and cleared
//               when the write for it is accepted. Register 0 is hard-wired
//               and never pending.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               set_valid, set_reg    - allocate a producer for set_reg
//               clr_valid, clr_reg    - write to clr_reg accepted this cycle
//               pending               - one bit per register, 1 = awaiting
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wr_scoreboard #(
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_valid,
  input  logic [ADDR_W-1:0]   set_reg,
  input  logic                clr_valid,
  input  logic [ADDR_W-1:0]   clr_reg,
  output logic [NUM_REGS-1:0] pending
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_pending_nxt;

  // Decode set/clear requests into one-hot masks. Requests aimed at
  // register 0 decode to nothing, so bit 0 can never change.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (set_valid && (set_reg != '0)) begin
      w_set_mask[set_reg] = 1'b1;
    end
    if (clr_valid && (clr_reg != '0)) begin
      w_clr_mask[clr_reg] = 1'b1;
    end
  end

  // Clear is applied first and set OR'd in afterwards, so a same-cycle
  // allocate of the register being written leaves it pending: the new
  // producer is still outstanding.
  always_comb begin
    w_pending_nxt    = (r_pending & ~w_clr_mask) | w_set_mask;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign pending = r_pending;

endmodule : rf_wr_scoreboard
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Arbitrates two writeback requesters (A = ALU, B = load unit)
//               onto a single register-file write port. Round-robin between
//               A and B, with an optional burst lock that lets B keep the
//               port for up to LOCK_MAX consecutive beats. Accepted writes
//               appear on the write port one cycle later. A pending-write
//               scoreboard tracks registers with outstanding producers.
// Ports       : clk, rst                 - clock, synchronous active-high rst
//               a_valid/a_ready          - requester A handshake
//               a_reg/a_data             - requester A destination and value
//               b_valid/b_ready          - requester B handshake
//               b_reg/b_data             - requester B destination and value
//               b_lock                   - B wants to keep the grant
//               alloc_valid/alloc_reg    - mark a register as pending
//               wr_en/wr_reg/wr_data     - register-file write port
//                                          (reg_write/write_reg/write_data)
//               wr_src                   - 0 = write from A, 1 = from B
//               pending                  - scoreboard, one bit per register
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int LOCK_MAX = regfile_pkg::LOCK_MAX
) (
  input  logic                clk,
  input  logic                rst,
  // Requester A (ALU writeback)
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_reg,
  input  logic [DATA_W-1:0]   a_data,
  // Requester B (load unit)
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_reg,
  input  logic [DATA_W-1:0]   b_data,
  input  logic                b_lock,
  // Producer allocation
  input  logic                alloc_valid,
  input  logic [ADDR_W-1:0]   alloc_reg,
  // Register-file write port
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_reg,
  output logic [DATA_W-1:0]   wr_data,
  output logic                wr_src,
  // Scoreboard
  output logic [NUM_REGS-1:0] pending
);

  import regfile_pkg::*;

  // Lock counter must be able to hold LOCK_MAX itself.
  localparam int c_cnt_w = $clog2(LOCK_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  // Counter value that, on one more B transfer, reaches LOCK_MAX.
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(LOCK_MAX - 1);
  // With LOCK_MAX of 1 (or less) a lock could never extend past the first
  // beat, so the lock state is never entered.
  localparam bit c_lock_enabled = (LOCK_MAX > 1);

  // Pointer encoding: 0 = A has priority on a tie, 1 = B has priority.
  localparam logic c_ptr_a = 1'b0;
  localparam logic c_ptr_b = 1'b1;

  // --------------------------------------------------------------------------
  // Arbiter state
  // --------------------------------------------------------------------------
  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic                r_ptr;
  logic                w_ptr_nxt;
  logic [c_cnt_w-1:0]  r_lock_cnt;
  logic [c_cnt_w-1:0]  w_lock_cnt_nxt;

  logic                w_a_xfer;
  logic                w_b_xfer;

  // Output register
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_reg;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_wr_src;

  // Scoreboard clear request
  logic                w_clr_valid;
  logic [ADDR_W-1:0]   w_clr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RR;
      r_ptr      <= c_ptr_a;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  // Ready generation and next-state logic. Ready depends only on the
  // requesters' valids, the current state and the pointer, so at most one
  // of a_ready/b_ready can be high in any cycle.
  always_comb begin
    a_ready        = 1'b0;
    b_ready        = 1'b0;
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_lock_cnt_nxt = r_lock_cnt;

    if (!rst) begin
      case (r_state)
        RR: begin
          a_ready = a_valid && (!b_valid || (r_ptr == c_ptr_a));
          b_ready = b_valid && (!a_valid || (r_ptr == c_ptr_b));
        end
        LOCK_B: begin
          b_ready = b_valid;
        end
        default: begin
          a_ready = 1'b0;
          b_ready = 1'b0;
        end
      endcase
    end

    w_a_xfer = a_valid && a_ready;
    w_b_xfer = b_valid && b_ready;

    case (r_state)
      RR: begin
        // The pointer always moves to the requester that did not win,
        // even when the winner was the only one asking.
        if (w_a_xfer) begin
          w_ptr_nxt = c_ptr_b;
        end else if (w_b_xfer) begin
          w_ptr_nxt = c_ptr_a;
          if (b_lock && c_lock_enabled) begin
            w_state_nxt    = LOCK_B;
            w_lock_cnt_nxt = c_cnt_one;
          end
        end
      end
      LOCK_B: begin
        // Exit on release, on an idle-and-unlocked cycle, or once this
        // transfer brings the beat count to LOCK_MAX. A always gets the
        // next tie after a lock ends.
        if (w_b_xfer) begin
          if (!b_lock || (r_lock_cnt == c_cnt_last)) begin
            w_state_nxt    = RR;
            w_ptr_nxt      = c_ptr_a;
            w_lock_cnt_nxt = '0;
          end else begin
            w_lock_cnt_nxt = r_lock_cnt + c_cnt_one;
          end
        end else if (!b_valid && !b_lock) begin
          w_state_nxt    = RR;
          w_ptr_nxt      = c_ptr_a;
          w_lock_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = RR;
        w_ptr_nxt      = c_ptr_a;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Write port register. wr_en pulses for one cycle per accepted write;
  // the address/data/source fields only update on a real write so the
  // port is quiet otherwise. Writes to register 0 are accepted but dropped.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
      r_wr_src  <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_a_xfer && (a_reg != '0)) begin
        r_wr_en   <= 1'b1;
        r_wr_reg  <= a_reg;
        r_wr_data <= a_data;
        r_wr_src  <= 1'b0;
      end else if (w_b_xfer && (b_reg != '0)) begin
        r_wr_en   <= 1'b1;
        r_wr_reg  <= b_reg;
        r_wr_data <= b_data;
        r_wr_src  <= 1'b1;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_reg  = r_wr_reg;
  assign wr_data = r_wr_data;
  assign wr_src  = r_wr_src;

  // --------------------------------------------------------------------------
  // Scoreboard. The clear uses the same transfer that loads the write
  // register, so the pending bit drops on the edge the write appears.
  // --------------------------------------------------------------------------
  assign w_clr_valid = w_a_xfer || w_b_xfer;
  assign w_clr_reg   = w_b_xfer ? b_reg : a_reg;

  rf_wr_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (alloc_valid),
    .set_reg   (alloc_reg),
    .clr_valid (w_clr_valid),
    .clr_reg   (w_clr_reg),
    .pending   (pending)
  );

endmodule : regfile_write_arbiter
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Self-checking bench for regfile_write_arbiter. A behavioural
//               model tracks the expected arbitration, write port and
//               scoreboard and is compared every cycle; directed scenarios
//               add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 16;
  localparam int LM = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, a_ready, b_valid, b_ready, b_lock;
  logic [AW-1:0] a_reg, b_reg, alloc_reg, wr_reg;
  logic [DW-1:0] a_data, b_data, wr_data;
  logic          alloc_valid, wr_en, wr_src;
  logic [NR-1:0] pending;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .LOCK_MAX(LM)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .b_lock(b_lock),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .wr_src(wr_src),
    .pending(pending)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  bit            m_ok = 1'b0;     // model has seen a reset edge
  bit            m_locked;        // B currently holds the port
  bit            m_b_first;       // on a tie, B wins
  int            m_beats;         // B beats in the current lock
  logic          m_wr_en;
  logic [AW-1:0] m_wr_reg;
  logic [DW-1:0] m_wr_data;
  logic          m_wr_src;
  bit            m_pend [NR];

  function automatic bit grant_a();
    if (rst || m_locked || !a_valid) return 1'b0;
    return !b_valid || !m_b_first;
  endfunction

  function automatic bit grant_b();
    if (rst || !b_valid) return 1'b0;
    return m_locked || !a_valid || m_b_first;
  endfunction

  initial begin : model
    bit ga, gb;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_ok = 1'b1; m_locked = 1'b0; m_b_first = 1'b0; m_beats = 0;
        m_wr_en = 1'b0; m_wr_reg = '0; m_wr_data = '0; m_wr_src = 1'b0;
        for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
      end else begin
        ga = grant_a();
        gb = grant_b();
        m_wr_en = 1'b0;
        if (ga) begin
          if (a_reg != 0) begin
            m_wr_en = 1'b1; m_wr_reg = a_reg; m_wr_data = a_data; m_wr_src = 1'b0;
            m_pend[a_reg] = 1'b0;
          end
        end
        if (gb) begin
          if (b_reg != 0) begin
            m_wr_en = 1'b1; m_wr_reg = b_reg; m_wr_data = b_data; m_wr_src = 1'b1;
            m_pend[b_reg] = 1'b0;
          end
        end
        if (alloc_valid && alloc_reg != 0) m_pend[alloc_reg] = 1'b1;
        if (!m_locked) begin
          if (ga) m_b_first = 1'b1;
          if (gb) begin
            m_b_first = 1'b0;
            if (b_lock) begin
              m_locked = 1'b1;
              m_beats  = 1;
            end
          end
        end else begin
          if (gb) begin
            m_beats++;
            if (!b_lock || m_beats >= LM) begin
              m_locked = 1'b0; m_beats = 0; m_b_first = 1'b0;
            end
          end else if (!b_valid && !b_lock) begin
            m_locked = 1'b0; m_beats = 0; m_b_first = 1'b0;
          end
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin : compare
    logic [NR-1:0] exp_p;
    forever begin
      @(negedge clk);
      if (m_ok) begin
        for (int i = 0; i < NR; i++) exp_p[i] = m_pend[i];
        check("a_ready", a_ready, grant_a());
        check("b_ready", b_ready, grant_b());
        check("wr_en",   wr_en,   m_wr_en);
        check("wr_reg",  wr_reg,  m_wr_reg);
        check("wr_data", wr_data, m_wr_data);
        check("wr_src",  wr_src,  m_wr_src);
        check("pending", pending, exp_p);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  initial begin : stim
    logic [3:0] seq;
    int nb, b_before_a;
    bit a_done;

    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; b_lock = 1'b0;
    a_reg = '0; a_data = '0; b_reg = '0; b_data = '0;
    alloc_valid = 1'b1; alloc_reg = 4'd3;   // must be discarded by reset
    tick(); tick();
    alloc_valid = 1'b0;
    check("rst_pending", pending, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    rst = 1'b0;

    // Round-robin with both requesters valid, pointer at A.
    a_valid = 1'b1; a_reg = 4'd1; a_data = 32'h0000_00A1;
    b_valid = 1'b1; b_reg = 4'd2; b_data = 32'h0000_00B2;
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seq = {seq[2:0], wr_src};
      if (i == 3) begin a_valid = 1'b0; b_valid = 1'b0; end
    end
    check("rr_src_seq", seq, 4'b0101);

    // Single A write moves the pointer to B.
    a_valid = 1'b1; a_reg = 4'd3; a_data = 32'h0000_0033;
    tick();
    // B locked stream of 10 beats competing with A.
    a_reg = 4'd4; a_data = 32'h0000_0044;
    b_valid = 1'b1; b_lock = 1'b1; b_reg = 4'd6; b_data = 32'h0000_0066;
    nb = 0; b_before_a = -1; a_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (wr_en) begin
        if (wr_src) begin
          nb++;
          if (nb == 10) begin b_valid = 1'b0; b_lock = 1'b0; end
        end else if (!a_done) begin
          a_done = 1'b1; b_before_a = nb; a_valid = 1'b0;
        end
      end
      if (nb == 10 && a_done) break;
    end
    check("lock_b_before_a", b_before_a, 8);
    check("lock_b_total", nb, 10);
    check("lock_a_granted", a_done, 1);
    tick();   // idle cycle lets the lock release

    // Write to register 0: accepted, no write performed, fields held.
    a_valid = 1'b1; a_reg = 4'd0; a_data = 32'h0000_1234;
    @(negedge clk);
    check("reg0_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    check("reg0_wr_en", wr_en, 0);
    check("reg0_wr_reg_held", wr_reg, 6);

    // Alloc reg 5, then B writes it.
    alloc_valid = 1'b1; alloc_reg = 4'd5;
    tick();
    alloc_valid = 1'b0;
    check("alloc5_set", pending[5], 1);
    b_valid = 1'b1; b_lock = 1'b0; b_reg = 4'd5; b_data = 32'h0005_671E;
    tick();
    b_valid = 1'b0;
    check("alloc5_clr", pending[5], 0);
    check("b5_wr_data", wr_data, 32'h0005_671E);
    check("b5_wr_src", wr_src, 1);

    // Same-cycle alloc and write to reg 7: set wins, write still happens.
    alloc_valid = 1'b1; alloc_reg = 4'd7;
    a_valid = 1'b1; a_reg = 4'd7; a_data = 32'h0000_0077;
    tick();
    alloc_valid = 1'b0; a_valid = 1'b0;
    check("same7_pending", pending[7], 1);
    check("same7_wr_en", wr_en, 1);
    check("same7_wr_reg", wr_reg, 7);

    // Reset during the second LOCK_B beat.
    b_valid = 1'b1; b_lock = 1'b1; b_reg = 4'd9; b_data = 32'h0000_0099;
    tick();
    rst = 1'b1;
    a_valid = 1'b1; a_reg = 4'd3; a_data = 32'h0000_0303;
    alloc_valid = 1'b1; alloc_reg = 4'd4;
    @(negedge clk);
    check("rst_b_ready", b_ready, 0);
    check("rst_a_ready", a_ready, 0);
    tick();
    rst = 1'b0; b_valid = 1'b0; b_lock = 1'b0; alloc_valid = 1'b0;
    check("lrst_wr_en", wr_en, 0);
    check("lrst_wr_reg", wr_reg, 0);
    check("lrst_wr_data", wr_data, 0);
    check("lrst_wr_src", wr_src, 0);
    check("lrst_pending", pending, 0);
    @(negedge clk);
    check("post_rst_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    check("post_rst_wr_en", wr_en, 1);
    check("post_rst_wr_reg", wr_reg, 3);

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_regfile_write_arbiter
`default_nettype wire

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, register data width.
REQ-002 Parameter: ADDR_W, 4, register index width (16 registers).
REQ-003 Parameter: LOCK_MAX, 8, maximum consecutive locked beats for requester B.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 a_valid/a_ready  in/out  1/1  requester A (ALU writeback) handshake.
REQ-008 a_reg/a_data  in  ADDR_W/DATA_W  requester A destination and value.
REQ-009 b_valid/b_ready  in/out  1/1  requester B (load unit) handshake.
REQ-010 b_reg/b_data  in  ADDR_W/DATA_W  requester B destination and value.
REQ-011 b_lock  in  1  B requests to keep the grant for its next beat.
REQ-012 alloc_valid/alloc_reg  in  1/ADDR_W  marks a register as having an outstanding producer.
REQ-013 wr_en/wr_reg/wr_data  out  1/ADDR_W/DATA_W  register-file write port (drives reg_write/write_reg/write_data).
REQ-014 wr_src  out  1  source of the current write: 0 = A, 1 = B.
REQ-015 pending  out  16  scoreboard; bit i high means register i awaits a write.

Function
REQ-016 Transfer occurs when valid && ready; at most one ready is high per cycle; ready is combinational from valid, state and pointer.
REQ-017 Requesters hold valid, reg and data stable until accepted.
REQ-018 State RR: only A valid -> A granted; only B valid -> B granted; both valid -> the requester named by the priority pointer is granted.
REQ-019 After each RR grant, the pointer moves to the non-granted requester.
REQ-020 RR -> LOCK_B on a B transfer with b_lock=1; the lock counter loads 1.
REQ-021 In LOCK_B: a_ready=0 and b_ready=b_valid; each B transfer increments the lock counter.
REQ-022 LOCK_B -> RR in any of these cases: a B transfer with b_lock=0; a cycle with b_valid=0 and b_lock=0; or the counter reaching LOCK_MAX on a transfer. On exit the pointer is set to A.
REQ-023 Output latency is 1 cycle: the edge after a transfer gives wr_en=1, wr_reg/wr_data from the winner, and wr_src.
REQ-024 A transfer to register 0 is accepted, but it gives wr_en=0 and clears no pending bit.
REQ-025 When wr_en=0, wr_reg, wr_data and wr_src hold their previous values.
REQ-026 Scoreboard: alloc_valid with alloc_reg!=0 sets pending[alloc_reg] at the next edge; a transfer clears pending[reg] at the same edge that registers the write.
REQ-027 When alloc and clear target the same register in the same cycle, the set wins.
REQ-028 pending[0] is always 0.
REQ-029 A write to a register whose pending bit is 0 is still performed; it is not an error.

Reset
REQ-030 While rst=1: a_ready=0 and b_ready=0, and no transfer occurs.
REQ-031 At a reset edge: wr_en=0, wr_reg=0, wr_data=0, wr_src=0, pending=0, state=RR, pointer=A, lock counter=0.
REQ-032 Reset has priority over every concurrent event, including during LOCK_B.
REQ-033 An alloc presented in the reset cycle is discarded.

Structure
REQ-034 Package regfile_pkg holds DATA_W, ADDR_W, NUM_REGS=16, LOCK_MAX and the state enum {RR, LOCK_B}.
REQ-035 One sub-module, rf_wr_scoreboard, holds the pending bits and their set/clear logic.
REQ-036 Arbiter FSM, pointer, lock counter and output register stay in the top module.

Verification
REQ-037 Scenario: A and B valid for 4 cycles, b_lock=0, pointer=A -> grants are A,B,A,B; wr_src is 0,1,0,1, each one cycle after its transfer.
REQ-038 Scenario: B sends 10 beats with b_lock=1 while A is valid -> 8 B writes, then A is granted; counter and state return to RR.
REQ-039 Scenario: A writes reg 0 with 0x1234 -> a_ready=1 and wr_en stays 0 the next cycle.
REQ-040 Scenario: alloc reg 5, then B writes reg 5 with 0x0005671E -> pending[5] goes 1, then 0; wr_data=0x0005671E.
REQ-041 Scenario: alloc reg 7 and A writes reg 7 in the same cycle -> pending[7]=1 and wr_en=1 with wr_reg=7.
REQ-042 Scenario: rst asserted in the second LOCK_B beat -> all outputs 0, state RR, pointer A; the next A request is granted immediately.
